bcd_countdown_timer: RTL and testbench

//  MM:SS countdown timer in BCD, one step per `tick` strobe from the scaled-clock tick generator.

---
 rtl/bcd_countdown_timer_pkg.sv | 40 ++++
 rtl/bcd_countdown_timer_if.sv | 27 ++
 rtl/bcd_digit_down.sv | 22 ++
 rtl/bcd_countdown_timer.sv | 108 ++++++++++
 tb/tb_bcd_countdown_timer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and helpers for the MM:SS BCD countdown timer.
// A stored time is four BCD digits; loaded values are clamped into range.
package bcd_countdown_timer_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      DONE
   } timer_state_t;

   typedef struct packed {
      bcd_digit_t min_tens;
      bcd_digit_t min_ones;
      bcd_digit_t sec_tens;
      bcd_digit_t sec_ones;
   } bcd_time_t;

   localparam bcd_digit_t DIGIT_MAX    = 4'd9;
   localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
   localparam bcd_time_t  TIME_ZERO    = 16'h0000;
   localparam bcd_time_t  TIME_ONE     = 16'h0001;

   function automatic bcd_digit_t clamp_digit(input bcd_digit_t digit, input bcd_digit_t max);
      return (digit > max) ? max : digit;
   endfunction

   // Any digit above 9 becomes 9; a seconds-tens digit above 5 becomes 5.
   function automatic bcd_time_t sanitise(input logic [7:0] min_raw, input logic [7:0] sec_raw);
      bcd_time_t t;
      t.min_tens = clamp_digit(min_raw[7:4], DIGIT_MAX);
      t.min_ones = clamp_digit(min_raw[3:0], DIGIT_MAX);
      t.sec_tens = clamp_digit(sec_raw[7:4], SEC_TENS_MAX);
      t.sec_ones = clamp_digit(sec_raw[3:0], DIGIT_MAX);
      return t;
   endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control and display bundle between the timer and its surroundings.
// The master side drives the controls; the slave is the timer itself.
interface bcd_countdown_timer_if;

   logic       tick;
   logic       start;
   logic       stop;
   logic       load;
   logic [7:0] load_min;
   logic [7:0] load_sec;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       running;
   logic       tick_en;
   logic       expired;

   modport master (
      output tick, start, stop, load, load_min, load_sec,
      input  min_bcd, sec_bcd, running, tick_en, expired
   );

   modport slave (
      input  tick, start, stop, load, load_min, load_sec,
      output min_bcd, sec_bcd, running, tick_en, expired
   );

endinterface

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down-counter chain: wraps 0 -> MAX when borrowed from.
module bcd_digit_down
   import bcd_countdown_timer_pkg::*;
#(
   parameter bcd_digit_t MAX = 4'd9
) (
   input  bcd_digit_t digit,
   input  logic       borrow_in,
   output bcd_digit_t next_digit,
   output logic       borrow_out
);

   always_comb begin
      next_digit = digit;
      if (borrow_in) begin
         next_digit = (digit == 4'd0) ? MAX : digit - 4'd1;
      end
   end

   assign borrow_out = (digit == 4'd0) && borrow_in;

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer stepped by divider ticks; gates the divider via tick_en
// and emits a one-cycle expired pulse on reaching 00:00.
module bcd_countdown_timer
   import bcd_countdown_timer_pkg::*;
#(
   parameter logic [7:0] RESET_MIN = 8'h01,
   parameter logic [7:0] RESET_SEC = 8'h00
) (
   input logic                 clock,
   input logic                 reset,
   bcd_countdown_timer_if.slave bus
);

   timer_state_t state_q, state_d;
   bcd_time_t    time_q, time_d;
   bcd_time_t    time_dec;
   logic         running_q, running_d;
   logic         tick_en_q;
   logic         expired_q, expired_d;

   logic         borrow_sec_tens;
   logic         borrow_min_ones;
   logic         borrow_min_tens;
   logic         borrow_unused;

   // Decremented value is always computed; it is only taken on an accepted tick.
   bcd_digit_down #(.MAX(DIGIT_MAX)) u_sec_ones (
      .digit      (time_q.sec_ones),
      .borrow_in  (1'b1),
      .next_digit (time_dec.sec_ones),
      .borrow_out (borrow_sec_tens)
   );

   bcd_digit_down #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .digit      (time_q.sec_tens),
      .borrow_in  (borrow_sec_tens),
      .next_digit (time_dec.sec_tens),
      .borrow_out (borrow_min_ones)
   );

   bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_ones (
      .digit      (time_q.min_ones),
      .borrow_in  (borrow_min_ones),
      .next_digit (time_dec.min_ones),
      .borrow_out (borrow_min_tens)
   );

   bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_tens (
      .digit      (time_q.min_tens),
      .borrow_in  (borrow_min_tens),
      .next_digit (time_dec.min_tens),
      .borrow_out (borrow_unused)
   );

   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      time_d    = time_q;
      expired_d = 1'b0;

      if (bus.load) begin
         time_d  = sanitise(bus.load_min, bus.load_sec);
         state_d = IDLE;
      end else if (bus.stop) begin
         if (state_q == RUN) begin
            state_d = PAUSE;
         end
      end else if (bus.start && (state_q == IDLE || state_q == PAUSE)) begin
         if (time_q != TIME_ZERO) begin
            state_d = RUN;
         end
      end else if (bus.tick && state_q == RUN) begin
         time_d = time_dec;
         if (time_q == TIME_ONE) begin
            state_d   = DONE;
            expired_d = 1'b1;
         end
      end

      running_d = (state_d == RUN);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      // NOTE: reset is synchronous; it only takes effect on a clock edge.
      if (reset) begin
         state_q   <= IDLE;
         time_q    <= {RESET_MIN, RESET_SEC};
         running_q <= 1'b0;
         tick_en_q <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         time_q    <= time_d;
         running_q <= running_d;
         tick_en_q <= running_d;
         expired_q <= expired_d;
      end
   end

   assign bus.min_bcd = {time_q.min_tens, time_q.min_ones};
   assign bus.sec_bcd = {time_q.sec_tens, time_q.sec_ones};
   assign bus.running = running_q;
   assign bus.tick_en = tick_en_q;
   assign bus.expired = expired_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: a seconds-count model checked every cycle,
// plus hand-computed spot values along a directed stimulus sequence.
module tb_bcd_countdown_timer;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   check_en = 1'b0;

   int   m_total;
   int   m_state;
   bit   m_run;
   bit   m_exp;

   bcd_countdown_timer_if bus();

   bcd_countdown_timer #(
      .RESET_MIN (8'h01),
      .RESET_SEC (8'h00)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int clamp(input int v, input int max);
      return (v > max) ? max : v;
   endfunction

   // Model: the time is a plain count of seconds.
   always @(posedge clock) begin
      if (reset) begin
         m_total = 60;
         m_state = M_IDLE;
         m_exp   = 1'b0;
      end else begin
         m_exp = 1'b0;
         if (bus.load) begin
            m_total = (clamp(int'(bus.load_min[7:4]), 9) * 10 + clamp(int'(bus.load_min[3:0]), 9)) * 60
                    + clamp(int'(bus.load_sec[7:4]), 5) * 10 + clamp(int'(bus.load_sec[3:0]), 9);
            m_state = M_IDLE;
         end else if (bus.stop) begin
            if (m_state == M_RUN) m_state = M_PAUSE;
         end else if (bus.start && (m_state == M_IDLE || m_state == M_PAUSE)) begin
            if (m_total != 0) m_state = M_RUN;
         end else if (bus.tick && m_state == M_RUN) begin
            m_total = m_total - 1;
            if (m_total == 0) begin
               m_state = M_DONE;
               m_exp   = 1'b1;
            end
         end
      end
      m_run = (m_state == M_RUN);
   end

   always @(negedge clock) begin
      if (check_en) begin
         check("model min_bcd", 32'(bus.min_bcd), 32'(to_bcd(m_total / 60)));
         check("model sec_bcd", 32'(bus.sec_bcd), 32'(to_bcd(m_total % 60)));
         check("model running", 32'(bus.running), 32'(m_run));
         check("model tick_en", 32'(bus.tick_en), 32'(m_run));
         check("model expired", 32'(bus.expired), 32'(m_exp));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step(input bit st, input bit sp, input bit ld, input bit tk,
                       input logic [7:0] lm, input logic [7:0] ls);
      bus.start    = st;
      bus.stop     = sp;
      bus.load     = ld;
      bus.tick     = tk;
      bus.load_min = lm;
      bus.load_sec = ls;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.load  = 1'b0;
      bus.tick  = 1'b0;
   endtask

   task automatic expect_time(input string name, input logic [7:0] m, input logic [7:0] s);
      check({name, " min"}, 32'(bus.min_bcd), 32'(m));
      check({name, " sec"}, 32'(bus.sec_bcd), 32'(s));
   endtask

   initial begin
      bus.start = 1'b0; bus.stop = 1'b0; bus.load = 1'b0; bus.tick = 1'b0;
      bus.load_min = 8'h00; bus.load_sec = 8'h00;

      @(posedge clock);
      #1;
      check_en = 1'b1;
      expect_time("reset", 8'h01, 8'h00);
      check("reset running", 32'(bus.running), 32'd0);
      check("reset expired", 32'(bus.expired), 32'd0);
      reset = 1'b0;

      // Full minute down to expiry.
      step(1, 0, 0, 0, 8'h00, 8'h00);
      check("start running", 32'(bus.running), 32'd1);
      step(0, 0, 0, 1, 8'h00, 8'h00);
      expect_time("first tick", 8'h00, 8'h59);
      repeat (59) step(0, 0, 0, 1, 8'h00, 8'h00);
      expect_time("expiry", 8'h00, 8'h00);
      check("expiry pulse", 32'(bus.expired), 32'd1);
      check("expiry tick_en", 32'(bus.tick_en), 32'd0);
      step(0, 0, 0, 0, 8'h00, 8'h00);
      check("expired one cycle", 32'(bus.expired), 32'd0);
      step(1, 0, 0, 0, 8'h00, 8'h00);
      check("done start ignored", 32'(bus.running), 32'd0);
      step(0, 0, 0, 1, 8'h00, 8'h00);

      // Borrow across minutes.
      step(0, 0, 1, 0, 8'h10, 8'h00);
      step(1, 0, 0, 0, 8'h00, 8'h00);
      step(0, 0, 0, 1, 8'h00, 8'h00);
      expect_time("10:00 tick", 8'h09, 8'h59);
      step(0, 0, 1, 0, 8'h00, 8'h10);
      step(1, 0, 0, 0, 8'h00, 8'h00);
      step(0, 0, 0, 1, 8'h00, 8'h00);
      expect_time("00:10 tick", 8'h00, 8'h09);

      // Pause holds the value and ignores ticks.
      step(0, 0, 1, 0, 8'h00, 8'h30);
      step(0, 0, 0, 1, 8'h00, 8'h00);
      step(1, 0, 0, 0, 8'h00, 8'h00);
      step(0, 1, 0, 0, 8'h00, 8'h00);
      repeat (5) step(0, 0, 0, 1, 8'h00, 8'h00);
      expect_time("paused", 8'h00, 8'h30);
      check("paused running", 32'(bus.running), 32'd0);
      step(1, 0, 0, 0, 8'h00, 8'h00);
      step(0, 0, 0, 1, 8'h00, 8'h00);
      expect_time("resumed", 8'h00, 8'h29);

      // Sanitise, and start refused at 00:00.
      step(0, 0, 1, 0, 8'hA7, 8'h7C);
      expect_time("sanitised", 8'h97, 8'h59);
      step(0, 0, 1, 0, 8'h00, 8'h00);
      step(1, 0, 0, 0, 8'h00, 8'h00);
      check("zero start running", 32'(bus.running), 32'd0);
      step(0, 0, 0, 1, 8'h00, 8'h00);
      check("zero no expired", 32'(bus.expired), 32'd0);

      // Same-cycle priorities.
      step(0, 0, 1, 0, 8'h00, 8'h05);
      step(1, 0, 0, 0, 8'h00, 8'h00);
      step(1, 1, 0, 1, 8'h00, 8'h00);
      expect_time("start+stop+tick", 8'h00, 8'h05);
      check("start+stop+tick running", 32'(bus.running), 32'd0);
      step(1, 0, 0, 0, 8'h00, 8'h00);
      step(0, 0, 1, 1, 8'h02, 8'h00);
      expect_time("load+tick", 8'h02, 8'h00);
      check("load+tick running", 32'(bus.running), 32'd0);
      step(1, 0, 0, 0, 8'h00, 8'h00);
      step(1, 0, 0, 1, 8'h00, 8'h00);
      expect_time("start held tick", 8'h01, 8'h59);

      // Reset wins over a final tick.
      step(0, 0, 1, 0, 8'h00, 8'h01);
      step(1, 0, 0, 0, 8'h00, 8'h00);
      reset = 1'b1;
      step(0, 0, 0, 1, 8'h00, 8'h00);
      reset = 1'b0;
      expect_time("reset mid-count", 8'h01, 8'h00);
      check("reset mid-count running", 32'(bus.running), 32'd0);
      check("reset mid-count expired", 32'(bus.expired), 32'd0);
      step(0, 0, 0, 0, 8'h00, 8'h00);
      check("reset no late expired", 32'(bus.expired), 32'd0);

      @(negedge clock);
      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
